sprite_fetch_sched: RTL and testbench

Per-scanline controller for the sprite slot chain and the sprite tile fetch path.
- Each line: clears the chain, drives the 80-cycle OAM scan (load), then holds query during pixel transfer.
- On a sprite hit it stalls the pixel pipe, fetches the sprite's two tile-row bytes from VRAM, and pushes the assembled row to the pixel mixer.
- Sits between the PPU line timer, the sprite chain, the VRAM read port and the mixer.

---
 rtl/sprite_fetch_sched.sv | 234 +++++++++++++++++++++++
 tb/tb_sprite_fetch_sched.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_fetch_sched.sv
// sprite_fetch_sched
//   Per-scanline sequencer for the sprite slot chain and the sprite tile-row
//   fetch. Each line it clears the chain, runs the OAM scan (chain_load), then
//   queries the chain during pixel transfer. On a hit it stalls the pixel pipe,
//   reads the two bitplane bytes of the sprite row from VRAM and hands the
//   assembled row to the mixer.
//
// Ports
//   clk, rst               clock; synchronous active-low reset
//   lcd_en                 PPU enable, low forces IDLE and zeroes outputs
//   line_start, xfer_done  line timer events
//   cfg_tall_sprites       8x16 sprite mode
//   chain_rst_n/load/query chain control
//   chain_valid/dy/tile/attrs  chain hit data, attrs = {prio, yflip, xflip, pal}
//   pix_stall              freezes lx and the background fetcher
//   vram_req/addr/data     VRAM read port, data VRAM_LAT cycles after request
//   spr_push/ready         row handshake to the mixer
//   spr_lo/hi/attrs        row bitplanes (bit7 = leftmost) and {prio, pal}
//
// state | meaning
// IDLE  | waiting for the first line_start
// CLEAR | chain reset pulse
// SCAN  | OAM scan, chain_load for SCAN_CYCLES cycles
// XFER  | pixel transfer, querying the chain
// FLO   | low bitplane read outstanding
// FHI   | high bitplane read outstanding
// PUSH  | row offered to the mixer
// DONE  | line finished, waiting for next line_start
module sprite_fetch_sched #(
    parameter int SCAN_CYCLES = 80,
    parameter int VRAM_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lcd_en,
    input  logic        line_start,
    input  logic        xfer_done,
    input  logic        cfg_tall_sprites,
    output logic        chain_rst_n,
    output logic        chain_load,
    output logic        chain_query,
    input  logic        chain_valid,
    input  logic [3:0]  chain_dy,
    input  logic [7:0]  chain_tile,
    input  logic [3:0]  chain_attrs,
    output logic        pix_stall,
    output logic        vram_req,
    output logic [12:0] vram_addr,
    input  logic [7:0]  vram_data,
    output logic        spr_push,
    input  logic        spr_ready,
    output logic [7:0]  spr_lo,
    output logic [7:0]  spr_hi,
    output logic [1:0]  spr_attrs
);

    localparam int CNT_MAX = (SCAN_CYCLES > VRAM_LAT) ? SCAN_CYCLES : VRAM_LAT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, CLEAR, SCAN, XFER, FLO, FHI, PUSH, DONE
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;

    logic [3:0] dy_q;
    logic [7:0] tile_q;
    logic [3:0] attrs_q;
    logic       tall_q;
    logic [7:0] lo_q, hi_q;

    logic run;
    logic lat_hit, lat_lo, lat_hi, drop;

    logic [3:0]  row;
    logic [7:0]  tile_eff;
    logic [12:0] addr_lo;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

    assign run = rst & lcd_en;

    // Row within the sprite; in tall mode row[3] selects the lower tile.
    always_comb begin
        if (attrs_q[2]) begin
            row = tall_q ? (4'd15 - dy_q) : {1'b0, 3'd7 - dy_q[2:0]};
        end else begin
            row = tall_q ? dy_q : {1'b0, dy_q[2:0]};
        end
        tile_eff = tall_q ? {tile_q[7:1], row[3]} : tile_q;
        addr_lo  = {1'b0, tile_eff, row[2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            dy_q    <= '0;
            tile_q  <= '0;
            attrs_q <= '0;
            tall_q  <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (drop) begin
                dy_q    <= '0;
                tile_q  <= '0;
                attrs_q <= '0;
                tall_q  <= 1'b0;
                lo_q    <= '0;
                hi_q    <= '0;
            end else begin
                if (lat_hit) begin
                    dy_q    <= chain_dy;
                    tile_q  <= chain_tile;
                    attrs_q <= chain_attrs;
                    tall_q  <= cfg_tall_sprites;
                end
                if (lat_lo) lo_q <= vram_data;
                if (lat_hi) hi_q <= vram_data;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        chain_rst_n = rst;
        chain_load  = 1'b0;
        chain_query = 1'b0;
        pix_stall   = 1'b0;
        vram_req    = 1'b0;
        vram_addr   = '0;
        spr_push    = 1'b0;
        spr_lo      = '0;
        spr_hi      = '0;
        spr_attrs   = '0;
        lat_hit     = 1'b0;
        lat_lo      = 1'b0;
        lat_hi      = 1'b0;
        drop        = 1'b0;

        if (!run) begin
            state_nx = IDLE;
            drop     = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    // pixel pipe is not running yet, so no stall is asserted
                end
                CLEAR: begin
                    chain_rst_n = 1'b0;
                    pix_stall   = 1'b1;
                    state_nx    = SCAN;
                    cnt_nx      = CW'(SCAN_CYCLES - 1);
                end
                SCAN: begin
                    chain_load = 1'b1;
                    pix_stall  = 1'b1;
                    if (cnt == '0) state_nx = XFER;
                    else           cnt_nx   = cnt - CW'(1);
                end
                XFER: begin
                    chain_query = 1'b1;
                    pix_stall   = chain_valid;
                    // a hit outranks xfer_done; done is re-sampled after the push
                    if (chain_valid) begin
                        lat_hit  = 1'b1;
                        state_nx = FLO;
                        cnt_nx   = CW'(VRAM_LAT);
                    end else if (xfer_done) begin
                        state_nx = DONE;
                    end
                end
                FLO: begin
                    pix_stall = 1'b1;
                    vram_req  = 1'b1;
                    vram_addr = addr_lo;
                    if (cnt == '0) begin
                        lat_lo   = 1'b1;
                        state_nx = FHI;
                        cnt_nx   = CW'(VRAM_LAT);
                    end else begin
                        cnt_nx = cnt - CW'(1);
                    end
                end
                FHI: begin
                    pix_stall = 1'b1;
                    vram_req  = 1'b1;
                    vram_addr = addr_lo | 13'd1;
                    if (cnt == '0) begin
                        lat_hi   = 1'b1;
                        state_nx = PUSH;
                    end else begin
                        cnt_nx = cnt - CW'(1);
                    end
                end
                PUSH: begin
                    pix_stall = 1'b1;
                    spr_push  = 1'b1;
                    spr_lo    = attrs_q[1] ? rev8(lo_q) : lo_q;
                    spr_hi    = attrs_q[1] ? rev8(hi_q) : hi_q;
                    spr_attrs = {attrs_q[3], attrs_q[0]};
                    if (spr_ready) state_nx = XFER;
                end
                DONE: begin
                    pix_stall = 1'b1;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase

            // line_start always restarts the line; mid-line it also drops the sprite
            if (line_start) begin
                state_nx = CLEAR;
                lat_hit  = 1'b0;
                lat_lo   = 1'b0;
                lat_hi   = 1'b0;
                drop     = (state != IDLE) && (state != DONE);
            end
        end
    end

endmodule

// File: tb/tb_sprite_fetch_sched.sv
// tb_sprite_fetch_sched
//   Drives line sequences with directed and random sprite hits and compares
//   every observable output against expectations computed from the address,
//   flip and timing rules of the block.
module tb_sprite_fetch_sched;

    localparam int SCAN_CYCLES = 80;
    localparam int VRAM_LAT    = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        lcd_en;
    logic        line_start;
    logic        xfer_done;
    logic        cfg_tall_sprites;
    logic        chain_rst_n;
    logic        chain_load;
    logic        chain_query;
    logic        chain_valid;
    logic [3:0]  chain_dy;
    logic [7:0]  chain_tile;
    logic [3:0]  chain_attrs;
    logic        pix_stall;
    logic        vram_req;
    logic [12:0] vram_addr;
    logic [7:0]  vram_data;
    logic        spr_push;
    logic        spr_ready;
    logic [7:0]  spr_lo;
    logic [7:0]  spr_hi;
    logic [1:0]  spr_attrs;

    int n_chk = 0;
    int n_err = 0;

    sprite_fetch_sched #(.SCAN_CYCLES(SCAN_CYCLES), .VRAM_LAT(VRAM_LAT)) dut (
        .clk(clk), .rst(rst), .lcd_en(lcd_en), .line_start(line_start),
        .xfer_done(xfer_done), .cfg_tall_sprites(cfg_tall_sprites),
        .chain_rst_n(chain_rst_n), .chain_load(chain_load), .chain_query(chain_query),
        .chain_valid(chain_valid), .chain_dy(chain_dy), .chain_tile(chain_tile),
        .chain_attrs(chain_attrs), .pix_stall(pix_stall), .vram_req(vram_req),
        .vram_addr(vram_addr), .vram_data(vram_data), .spr_push(spr_push),
        .spr_ready(spr_ready), .spr_lo(spr_lo), .spr_hi(spr_hi), .spr_attrs(spr_attrs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: byte address of a sprite row bitplane, by plain arithmetic.
    function automatic int ref_addr(input int tile, input int dy, input int attrs,
                                    input int tall, input int hi);
        int r, t;
        if ((attrs / 4) % 2 == 1) r = tall ? 15 - dy : 7 - (dy % 8);
        else                      r = tall ? dy : dy % 8;
        t = tall ? (tile - tile % 2) + r / 8 : tile;
        return t * 16 + (r % 8) * 2 + hi;
    endfunction

    function automatic int ref_row(input int b, input int attrs);
        int r = 0;
        if ((attrs / 2) % 2 == 0) return b;
        for (int i = 0; i < 8; i++) r = r * 2 + ((b >> i) % 2);
        return r;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_load"},  chain_load, 0);
        check({tag, "_query"}, chain_query, 0);
        check({tag, "_stall"}, pix_stall, 0);
        check({tag, "_req"},   vram_req, 0);
        check({tag, "_addr"},  vram_addr, 0);
        check({tag, "_push"},  spr_push, 0);
        check({tag, "_data"},  {spr_lo, spr_hi, spr_attrs}, 0);
    endtask

    // Entered at +1 of the CLEAR cycle; leaves at +1 of an XFER cycle.
    task automatic scan_phase();
        int n = 0;
        #1;
        check("clear_rst_n", chain_rst_n, 0);
        check("clear_load", chain_load, 0);
        step();
        #1;
        while (chain_load === 1'b1 && n < 200) begin
            if (chain_query !== 1'b0 || chain_rst_n !== 1'b1) check("scan_ctrl", {chain_query, chain_rst_n}, 1);
            n++;
            step();
            #1;
        end
        check("scan_len", n, SCAN_CYCLES);
        check("xfer_query", chain_query, 1);
        check("xfer_stall", pix_stall, 0);
        step();
    endtask

    task automatic start_line();
        line_start = 1'b1;
        #1;
        check("ls_rst_n", chain_rst_n, 1);
        step();
        line_start = 1'b0;
        scan_phase();
    endtask

    task automatic end_line();
        xfer_done = 1'b1;
        #1;
        check("done_in_stall", pix_stall, 0);
        step();
        xfer_done = 1'b0;
        #1;
        check("done_stall", pix_stall, 1);
        check("done_query", chain_query, 0);
        check("done_push", spr_push, 0);
        step();
    endtask

    // Entered at +1 of an XFER cycle; leaves at +1 of the XFER cycle after accept.
    task automatic fetch_one(input int tile, input int dy, input int attrs, input int tall,
                             input int lo, input int hi, input int wait_n, input logic with_done);
        int exp_lo, exp_hi;
        cfg_tall_sprites = tall[0];
        chain_valid = 1'b1;
        chain_tile  = 8'(tile);
        chain_dy    = 4'(dy);
        chain_attrs = 4'(attrs);
        xfer_done   = with_done;
        #1;
        check("hit_stall", pix_stall, 1);
        check("hit_query", chain_query, 1);
        step();
        chain_valid = 1'b0;
        xfer_done   = 1'b0;
        chain_tile  = 8'($urandom);
        chain_dy    = 4'($urandom);
        chain_attrs = 4'($urandom);
        for (int h = 0; h < 2; h++) begin
            for (int k = 0; k <= VRAM_LAT; k++) begin
                vram_data = (k == VRAM_LAT) ? 8'(h ? hi : lo) : 8'($urandom);
                #1;
                check("f_req", vram_req, 1);
                check("f_addr", vram_addr, ref_addr(tile, dy, attrs, tall, h));
                check("f_stall", pix_stall, 1);
                check("f_query", chain_query, 0);
                check("f_push", spr_push, 0);
                step();
            end
        end
        vram_data = 8'($urandom);
        exp_lo = ref_row(lo, attrs);
        exp_hi = ref_row(hi, attrs);
        for (int s = 0; s <= wait_n; s++) begin
            spr_ready = (s == wait_n);
            #1;
            check("p_push", spr_push, 1);
            check("p_lo", spr_lo, exp_lo);
            check("p_hi", spr_hi, exp_hi);
            check("p_attrs", spr_attrs, (attrs / 8) * 2 + attrs % 2);
            check("p_stall", pix_stall, 1);
            check("p_req", vram_req, 0);
            step();
        end
        spr_ready = 1'b0;
    endtask

    task automatic idle_xfer(input int n);
        for (int i = 0; i < n; i++) begin
            chain_valid = 1'b0;
            #1;
            check("gap_stall", pix_stall, 0);
            check("gap_query", chain_query, 1);
            step();
        end
    endtask

    initial begin
        rst = 1'b0; lcd_en = 1'b1; line_start = 1'b0; xfer_done = 1'b0;
        cfg_tall_sprites = 1'b0; chain_valid = 1'b0; chain_dy = '0; chain_tile = '0;
        chain_attrs = '0; vram_data = '0; spr_ready = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        #1;
        check("idle_rst_n", chain_rst_n, 1);
        check_quiet("idle");
        step();

        // basic line with no hits
        start_line();
        idle_xfer(3);
        end_line();

        // single 8x8 hit
        start_line();
        idle_xfer(2);
        fetch_one(8'h12, 3, 0, 0, 8'hF0, 8'h0F, 0, 1'b0);
        idle_xfer(1);
        end_line();

        // tall, yflip, xflip; xfer_done coincides with the hit
        start_line();
        fetch_one(8'h13, 2, 4'b0110, 1, 8'h80, 8'h03, 1, 1'b1);
        idle_xfer(1);
        end_line();

        // two sprites at the same lx, second held by the mixer
        start_line();
        fetch_one(8'h40, 5, 4'b1001, 0, 8'hA5, 8'h3C, 0, 1'b0);
        fetch_one(8'h41, 9, 4'b1010, 0, 8'h01, 8'hFE, 4, 1'b0);
        idle_xfer(1);
        end_line();

        // abort during the high-byte fetch
        start_line();
        cfg_tall_sprites = 1'b0;
        chain_valid = 1'b1; chain_tile = 8'h22; chain_dy = 4'd1; chain_attrs = 4'd0;
        step();
        chain_valid = 1'b0;
        repeat (VRAM_LAT + 1) step();
        line_start = 1'b1;
        #1;
        check("ab_req_fhi", vram_req, 1);
        check("ab_addr_fhi", vram_addr, 13'h223);
        step();
        line_start = 1'b0;
        #1;
        check("ab_req_off", vram_req, 0);
        check("ab_push_off", spr_push, 0);
        scan_phase();
        end_line();

        // mid-scan reset
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        repeat (12) step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rst_rst_n", chain_rst_n, 0);
            check("rst_load", chain_load, 0);
            check("rst_stall", pix_stall, 0);
            step();
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("post_rst_n", chain_rst_n, 1);
            check_quiet("post_rst");
            step();
        end

        // lcd_en low during transfer
        start_line();
        lcd_en = 1'b0;
        #1;
        check("lcd_query", chain_query, 0);
        check("lcd_rst_n", chain_rst_n, 1);
        check("lcd_stall", pix_stall, 0);
        step();
        lcd_en = 1'b1;
        #1;
        check_quiet("lcd_idle");
        step();

        // randomized lines
        for (int ln = 0; ln < 8; ln++) begin
            start_line();
            for (int h = $urandom_range(0, 3); h > 0; h--) begin
                idle_xfer($urandom_range(0, 2));
                fetch_one($urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 15),
                          $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 255),
                          $urandom_range(0, 4), 1'($urandom_range(0, 1)));
            end
            idle_xfer(1);
            end_line();
            repeat ($urandom_range(0, 3)) step();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
